flp_unpack_pipe: RTL
====================

Name: flp_unpack_pipe

Overview:
- Parametrised, pipelined successor to the combinational FP unpacker.
- Accepts packed IEEE-754 words under a valid/ready handshake and classifies them as zero, subnormal, inf, qNaN or sNaN.
- Normalises subnormals with a leading-zero count and shift, so downstream adders and multipliers always see a hidden-1 significand and a signed, unbiased exponent.
- Sits between the vector-lane operand fetch and the FP datapath; optional tag bits travel alongside each operand.

Parameters:
- EWIDTH, 8, exponent field width.
- SWIDTH, 23, stored fraction width.
- TWIDTH, 4, sideband tag width, passed through unchanged.
- Derived, not overridable: BIAS = 2^(EWIDTH-1)-1; XWIDTH = EWIDTH+2, width of the signed unbiased exponent.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_fpd  in  EWIDTH+SWIDTH+1  packed FP operand
- i_tag  in  TWIDTH  sideband tag
- i_vld  in  1  input valid
- o_rdy  out  1  input ready
- o_vld  out  1  output valid
- i_rdy  in  1  downstream ready
- o_tag  out  TWIDTH  tag of the output operand
- o_sn  out  1  sign
- o_ex  out  XWIDTH  signed unbiased exponent
- o_sg  out  SWIDTH+1  significand, hidden bit at MSB
- o_zero  out  1  operand is ±0
- o_sub  out  1  input was subnormal
- o_inf  out  1  operand is ±inf
- o_nan  out  1  operand is any NaN
- o_snan  out  1  operand is a signalling NaN (fraction MSB = 0, fraction != 0)

Behaviour:
- Two-stage elastic pipeline.
  - S1: extract fields, classify, compute lzc of the fraction.
  - S2: shift and adjust the exponent.
  - Per-stage valid bits v1 and v2.
- Handshake:
  - adv2 = !v2 | i_rdy
  - adv1 = !v1 | adv2
  - o_rdy = adv1, combinational
  - o_vld = v2
- Transfers:
  - Input transfer on i_vld & o_rdy; S1 loads and v1 <= 1.
  - If adv1 without input, v1 <= 0.
  - S2 loads from S1 on adv2, taking v2 <= v1.
- Latency: 2 cycles from input accept to o_vld when unstalled. Throughput is 1 operand/cycle.
- While o_vld & !i_rdy, every output holds stable.
- Reset: v1, v2 <= 0, so o_vld = 0. All data outputs and flags go to 0, and o_rdy reads 1 in the first cycle after reset.
  - Reset asserted mid-operation discards all in-flight operands; nothing is emitted.
- Field definitions: E = exponent field, F = fraction field.
- Classification and outputs, in priority order:
  - E==0, F==0: zero. ex=0, sg=0, zero=1.
  - E==0, F!=0: subnormal. L = lzc(F), range 0..SWIDTH-1.
    - sg = F << (L+1), truncated to SWIDTH+1 bits so the MSB is 1.
    - ex = 1-BIAS-(L+1) = -BIAS-L.
    - sub=1.
  - E==all-ones, F==0: inf. ex=BIAS+1, sg={1,0...}, inf=1.
  - E==all-ones, F!=0: NaN. ex=BIAS+1, sg={1,F}, nan=1, snan=!F[SWIDTH-1].
  - Otherwise: normal. ex = E-BIAS, sign-extended to XWIDTH; sg = {1,F}.
- o_sn always equals the input sign bit, including zero and NaN.
- Exponent arithmetic is done in XWIDTH-bit signed two's complement. No overflow is possible over the derived range.
- The lzc of an all-zero fraction is don't-care; the zero path overrides it.
- Simultaneous input accept and output drain in the same cycle is legal and must not drop or duplicate an operand.

Decomposition:
- Shared header flp_defs.vh holds:
  - the FP32 constants (EWIDTH/SWIDTH/BIAS);
  - the class-encoding localparams, shared with the pack module.
- One sub-module: flp_lzc, a parametrised leading-zero counter.
  - Input width SWIDTH; output width $clog2(SWIDTH+1).
  - Purely combinational, instantiated in S1.

Test Plan:
- 0x3F80_0000 with i_rdy=1 → two cycles later o_vld=1, sn=0, ex=0, sg=0x80_0000, all flags 0.
- 0x0000_0001 → sub=1, ex=-149 (9'h16B in XWIDTH=10: 10'h36B), sg=0x80_0000. Also 0x0040_0000 → ex=-127, sg=0x80_0000.
- Specials:
  - 0x8000_0000 → zero=1, sn=1.
  - 0xFF80_0000 → inf=1, sn=1, ex=128.
  - 0x7FC0_0000 → nan=1, snan=0.
  - 0x7F80_0001 → nan=1, snan=1, sg=0x80_0001.
- Back-to-back stream of 8 operands with tags 0..7, i_rdy=0 for cycles 3–5:
  - o_rdy drops after both stages fill;
  - outputs stay stable during the stall;
  - all 8 are emitted in order with matching tags; none lost or duplicated.
- Assert rst for one cycle while both stages are valid → next cycle o_vld=0, o_rdy=1, outputs 0; the next accepted operand appears after 2 cycles.
- Parameter sweep EWIDTH=5, SWIDTH=10 (FP16):
  - 0x0001 → ex=-24, sg=0x400, sub=1.
  - 0x7C00 → inf=1, ex=16.

Source files
------------

// File: rtl/flp_unpack_pipe_pkg.sv
// Shared FP unpack/pack definitions: default FP32 geometry and operand class encoding.
package flp_unpack_pipe_pkg;

  localparam int FP32_EWIDTH = 8;
  localparam int FP32_SWIDTH = 23;
  localparam int FP32_BIAS   = 127;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_INF,
    CLS_NAN,
    CLS_NORM
  } flp_cls_e;

  function automatic int flp_bias(input int ewidth);
    return (1 << (ewidth - 1)) - 1;
  endfunction

endpackage

// File: rtl/flp_unpack_pipe_if.sv
// Operand-in / unpacked-operand-out handshake bundle for flp_unpack_pipe.
interface flp_unpack_pipe_if #(
  parameter int EWIDTH = flp_unpack_pipe_pkg::FP32_EWIDTH,
  parameter int SWIDTH = flp_unpack_pipe_pkg::FP32_SWIDTH,
  parameter int TWIDTH = 4
);
  localparam int XWIDTH = EWIDTH + 2;

  logic [EWIDTH+SWIDTH:0] i_fpd;
  logic [TWIDTH-1:0]      i_tag;
  logic                   i_vld;
  logic                   o_rdy;
  logic                   o_vld;
  logic                   i_rdy;
  logic [TWIDTH-1:0]      o_tag;
  logic                   o_sn;
  logic [XWIDTH-1:0]      o_ex;
  logic [SWIDTH:0]        o_sg;
  logic                   o_zero;
  logic                   o_sub;
  logic                   o_inf;
  logic                   o_nan;
  logic                   o_snan;

  modport slave (
    input  i_fpd, i_tag, i_vld, i_rdy,
    output o_rdy, o_vld, o_tag, o_sn, o_ex, o_sg, o_zero, o_sub, o_inf, o_nan, o_snan
  );

  modport master (
    output i_fpd, i_tag, i_vld, i_rdy,
    input  o_rdy, o_vld, o_tag, o_sn, o_ex, o_sg, o_zero, o_sub, o_inf, o_nan, o_snan
  );

endinterface

// File: rtl/flp_unpack_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module flp_lzc #(
  parameter int WIDTH = 23
) (
  input  logic [WIDTH-1:0]            i_vec,
  output logic [$clog2(WIDTH+1)-1:0]  o_cnt
);
  localparam int CWIDTH = $clog2(WIDTH + 1);

  logic found;

  always_comb begin
    o_cnt = CWIDTH'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && i_vec[WIDTH-1-i]) begin
        o_cnt = CWIDTH'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flp_unpack_pipe.sv
// Two-stage elastic IEEE-754 unpacker: S1 classifies and counts leading zeros,
// S2 normalises subnormals and produces the signed unbiased exponent.
module flp_unpack_pipe import flp_unpack_pipe_pkg::*; #(
  parameter int EWIDTH = FP32_EWIDTH,
  parameter int SWIDTH = FP32_SWIDTH,
  parameter int TWIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  flp_unpack_pipe_if.slave bus
);
  localparam int BIAS   = flp_bias(EWIDTH);
  localparam int XWIDTH = EWIDTH + 2;
  localparam int LWIDTH = $clog2(SWIDTH + 1);

  logic              adv1, adv2;
  logic [EWIDTH-1:0] e_in;
  logic [SWIDTH-1:0] f_in;
  logic [LWIDTH-1:0] lz_in;
  flp_cls_e          cls_in;

  logic              v1_d, v1_q, sn1_d, sn1_q;
  flp_cls_e          cls1_d, cls1_q;
  logic [EWIDTH-1:0] e1_d, e1_q;
  logic [SWIDTH-1:0] f1_d, f1_q;
  logic [LWIDTH-1:0] lz1_d, lz1_q;
  logic [TWIDTH-1:0] tag1_d, tag1_q;

  logic              v2_d, v2_q, sn2_d, sn2_q;
  logic [TWIDTH-1:0] tag2_d, tag2_q;
  logic [XWIDTH-1:0] ex2_d, ex2_q;
  logic [SWIDTH:0]   sg2_d, sg2_q;
  logic              zero2_d, zero2_q, sub2_d, sub2_q, inf2_d, inf2_q;
  logic              nan2_d, nan2_q, snan2_d, snan2_q;

  flp_lzc #(.WIDTH(SWIDTH)) u_lzc (
    .i_vec (f_in),
    .o_cnt (lz_in)
  );

  always_comb begin
    e_in = bus.i_fpd[SWIDTH +: EWIDTH];
    f_in = bus.i_fpd[SWIDTH-1:0];
    if (e_in == '0)      cls_in = (f_in == '0) ? CLS_ZERO : CLS_SUB;
    else if (e_in == '1) cls_in = (f_in == '0) ? CLS_INF  : CLS_NAN;
    else                 cls_in = CLS_NORM;
  end

  always_comb begin
    adv2 = !v2_q || bus.i_rdy;
    adv1 = !v1_q || adv2;

    v1_d   = v1_q;
    sn1_d  = sn1_q;
    cls1_d = cls1_q;
    e1_d   = e1_q;
    f1_d   = f1_q;
    lz1_d  = lz1_q;
    tag1_d = tag1_q;
    if (adv1) begin
      v1_d = bus.i_vld;
      if (bus.i_vld) begin
        sn1_d  = bus.i_fpd[EWIDTH+SWIDTH];
        cls1_d = cls_in;
        e1_d   = e_in;
        f1_d   = f_in;
        lz1_d  = lz_in;
        tag1_d = bus.i_tag;
      end
    end

    v2_d    = v2_q;
    tag2_d  = tag2_q;
    sn2_d   = sn2_q;
    ex2_d   = ex2_q;
    sg2_d   = sg2_q;
    zero2_d = zero2_q;
    sub2_d  = sub2_q;
    inf2_d  = inf2_q;
    nan2_d  = nan2_q;
    snan2_d = snan2_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        tag2_d  = tag1_q;
        sn2_d   = sn1_q;
        zero2_d = 1'b0;
        sub2_d  = 1'b0;
        inf2_d  = 1'b0;
        nan2_d  = 1'b0;
        snan2_d = 1'b0;
        case (cls1_q)
          CLS_ZERO: begin
            ex2_d   = '0;
            sg2_d   = '0;
            zero2_d = 1'b1;
          end
          // Shifting {F,0} by lzc equals F << (lzc+1) truncated, leaving the leading 1 at the MSB.
          CLS_SUB: begin
            sg2_d  = {f1_q, 1'b0} << lz1_q;
            ex2_d  = -XWIDTH'(BIAS) - XWIDTH'(lz1_q);
            sub2_d = 1'b1;
          end
          CLS_INF: begin
            ex2_d  = XWIDTH'(BIAS + 1);
            sg2_d  = {1'b1, {SWIDTH{1'b0}}};
            inf2_d = 1'b1;
          end
          CLS_NAN: begin
            ex2_d   = XWIDTH'(BIAS + 1);
            sg2_d   = {1'b1, f1_q};
            nan2_d  = 1'b1;
            snan2_d = !f1_q[SWIDTH-1];
          end
          default: begin
            ex2_d = XWIDTH'(e1_q) - XWIDTH'(BIAS);
            sg2_d = {1'b1, f1_q};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      sn1_q   <= 1'b0;
      cls1_q  <= CLS_ZERO;
      e1_q    <= '0;
      f1_q    <= '0;
      lz1_q   <= '0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      tag2_q  <= '0;
      sn2_q   <= 1'b0;
      ex2_q   <= '0;
      sg2_q   <= '0;
      zero2_q <= 1'b0;
      sub2_q  <= 1'b0;
      inf2_q  <= 1'b0;
      nan2_q  <= 1'b0;
      snan2_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      sn1_q   <= sn1_d;
      cls1_q  <= cls1_d;
      e1_q    <= e1_d;
      f1_q    <= f1_d;
      lz1_q   <= lz1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      tag2_q  <= tag2_d;
      sn2_q   <= sn2_d;
      ex2_q   <= ex2_d;
      sg2_q   <= sg2_d;
      zero2_q <= zero2_d;
      sub2_q  <= sub2_d;
      inf2_q  <= inf2_d;
      nan2_q  <= nan2_d;
      snan2_q <= snan2_d;
    end
  end

  always_comb begin
    bus.o_rdy  = adv1;
    bus.o_vld  = v2_q;
    bus.o_tag  = tag2_q;
    bus.o_sn   = sn2_q;
    bus.o_ex   = ex2_q;
    bus.o_sg   = sg2_q;
    bus.o_zero = zero2_q;
    bus.o_sub  = sub2_q;
    bus.o_inf  = inf2_q;
    bus.o_nan  = nan2_q;
    bus.o_snan = snan2_q;
  end

endmodule
